write_back_queue: RTL and testbench
===================================

// Module: write_back_queue
// PURPOSE
// - Registered, parametrised write-back/retire stage between the memory stage and the register file.
// - Buffers up to DEPTH completed instructions behind a valid/ready handshake and retires at most one per cycle.
// - On retire it aligns and sign/zero-extends load data, writes rd, and resolves branch/JAL/JALR redirects.
// - Flags misaligned loads and flushes younger entries on a redirect or trap.
// PARAMETERS
// XLEN   32  datapath / PC width
// DEPTH  2   queue entries (power of 2, >=2)
// NREG   32  architectural registers; rd width = $clog2(NREG)
// PORTS
// clk             in   1      clock, all state on rising edge
// rst_n           in   1      synchronous reset, active low
// in_valid        in   1      memory stage offers an entry
// in_ready        out  1      queue can accept (= count < DEPTH)
// in_pc           in   XLEN   PC of the instruction
// in_opcode       in   7      RV32 opcode
// in_funct3       in   3      load size/sign selector
// in_rd           in   RDW    destination register
// in_alu_result   in   XLEN   ALU result / load address / branch-taken flag in bit0
// in_rs1_data     in   XLEN   rs1 value (JALR base)
// in_imm          in   XLEN   sign-extended immediate (B/J/I per opcode)
// in_load_data    in   XLEN   raw aligned memory word
// wb_stall        in   1      hold retirement this cycle
// flush           in   1      discard all queued entries
// rf_we           out  1      register-file write enable
// rf_rd           out  RDW    write address
// rf_wdata        out  XLEN   write data
// retire_valid    out  1      an instruction retired this cycle
// retire_pc       out  XLEN   its PC
// redirect_valid  out  1      fetch must restart at redirect_pc
// redirect_pc     out  XLEN   target
// trap_valid      out  1      misaligned load retired (no rf write)
// BEHAVIOUR
// - Reset (rst_n=0 at an edge): count=0, pointers=0; all outputs 0 in the following cycle; in_ready=1 after reset.
// - Push: in_valid && in_ready captures one entry at the tail. in_ready depends only on count, never on same-cycle pop.
// - Retire: if count>0 && !wb_stall && !flush, the head is popped. All outputs are registered and valid the next cycle.
//   Min latency is accept at edge t -> retire_valid visible after edge t+1. Outputs not retiring are 0 (single-cycle pulses).
// - Write data by opcode:
//   - OP / OP-IMM / LUI / AUIPC -> alu_result.
//   - LOAD -> extracted lane.
//   - JAL (1101111) / JALR (1100111) -> pc+4.
//   - Others (BRANCH, STORE) -> no write.
//   - rf_we is forced 0 when rd==0.
// - Load extract: off=alu_result[1:0].
//   - LB/LBU sign/zero-extend byte[off].
//   - LH/LHU use half[off[1]].
//   - LW uses the full word.
//   - Misaligned (LH/LHU with off[0]=1, LW with off!=0): trap_valid=1, rf_we=0, then treated as a redirect to flush younger entries (redirect_valid=0).
// - Redirect targets: all arithmetic is XLEN modulo 2^XLEN; JALR clears bit0.
//   - BRANCH with alu_result[0]=1 -> pc+imm.
//   - JAL -> pc+imm.
//   - JALR -> (rs1+imm)&~1.
//   - redirect_valid pulses with retire_valid.
// - Redirect/trap retire: every other queued entry and any same-cycle push are dropped; count becomes 0.
// - flush: highest priority. Clears the queue, suppresses retire and push that cycle; outputs are 0 next cycle.
// - Full queue with simultaneous pop: push is refused (in_ready=0); count becomes DEPTH-1.
// - Pointers wrap modulo DEPTH. count uses $clog2(DEPTH)+1 bits.
// - wb_stall: holds the head and queue contents; push still allowed while not full.
// - Reset mid-operation discards all entries; no write or redirect is emitted for them.
// STRUCTURE
// - common package additions: wb_entry_t (packed struct of the in_* fields); opcode constants
//   OPC_LOAD/OP/OPIMM/LUI/AUIPC/BRANCH/JAL/JALR; funct3 constants F3_LB/LH/LW/LBU/LHU.
// - Sub-module: wb_fifo #(type T, DEPTH), a synchronous circular buffer with push/pop/clear.
//   Extract/redirect logic stays in the top as comb functions feeding the output registers.
// TESTING
// - ADDI rd=5, alu=0x0000_002A -> next cycle rf_we=1, rf_rd=5, rf_wdata=0x2A, retire_valid=1.
// - LB addr off=3, data=0x80FF_0000 -> rf_wdata=0xFFFF_FF80; LBU same -> 0x0000_0080;
//   LHU off=2 -> 0x0000_80FF.
// - JALR pc=0x100, rs1=0x2001, imm=4, rd=1 -> rf_wdata=0x104, redirect_pc=0x2004;
//   the queued younger entry is never retired.
// - BRANCH pc=0x200, imm=-8, alu[0]=1 -> redirect_pc=0x1F8, rf_we=0; alu[0]=0 -> no redirect.
// - LW off=2 -> trap_valid=1, rf_we=0, queue emptied.
// - wb_stall held 3 cycles with DEPTH=2 pushes -> in_ready=0; release -> two in-order retires;
//   flush mid-stream -> nothing retires; rst_n=0 -> all outputs 0.

Source files
------------

// File: rtl/write_back_queue_pkg.sv
// Shared types and constants for the write-back queue: entry layout, RV32 opcodes, load funct3 codes.
// No logic here; widths below fix the entry format used by the queue storage.
// Default widths match a 32-bit core with 32 architectural registers.
package write_back_queue_pkg;

  localparam int WB_XLEN = 32;
  localparam int WB_NREG = 32;
  localparam int WB_RDW  = $clog2(WB_NREG);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // One completed instruction as handed over by the memory stage.
  typedef struct packed {
    logic [WB_XLEN-1:0] pc;
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [WB_RDW-1:0]  rd;
    logic [WB_XLEN-1:0] alu_result;
    logic [WB_XLEN-1:0] rs1_data;
    logic [WB_XLEN-1:0] imm;
    logic [WB_XLEN-1:0] load_data;
  } wb_entry_t;

endpackage

// File: rtl/write_back_queue_fifo.sv
// Generic synchronous circular buffer with push/pop/clear; head is read combinationally.
// Latency: a push at edge t is visible at o_head after edge t (when the buffer was empty).
// Backpressure: caller must not push when full; clear wins over push and pop in the same cycle.
module wb_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  T                         i_dat,
  input  logic                     i_pop,
  input  logic                     i_clear,
  output T                         o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Pointer and occupancy tracking; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (i_push && !i_pop)      r_count <= r_count + CW'(1);
      else if (!i_push && i_pop) r_count <= r_count - CW'(1);
    end
  end

  // Entry storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (i_push && !i_clear) r_mem[r_wr_ptr] <= i_dat;
  end

endmodule

// File: rtl/write_back_queue.sv
// Write-back stage: queues completed instructions, retires one per cycle, writes rd, resolves redirects/traps.
// Latency: accept at edge t -> registered retire outputs after edge t+1; all outputs are single-cycle pulses.
// Backpressure: in_ready = count < DEPTH (independent of same-cycle pop); wb_stall holds the head, flush drops all.
module write_back_queue
  import write_back_queue_pkg::*;
#(
  parameter int XLEN  = WB_XLEN,
  parameter int DEPTH = 2,
  parameter int NREG  = WB_NREG,
  localparam int RDW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic [RDW-1:0]  in_rd,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_load_data,
  input  logic            wb_stall,
  input  logic            flush,
  output logic            rf_we,
  output logic [RDW-1:0]  rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic            retire_valid,
  output logic [XLEN-1:0] retire_pc,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            trap_valid
);

  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t       w_in_entry;
  wb_entry_t       w_head;
  logic [CW-1:0]   w_count;
  logic            w_retire;
  logic            w_push;
  logic            w_clear;
  logic [1:0]      w_off;
  logic            w_misalign;
  logic            w_we;
  logic [XLEN-1:0] w_wdata;
  logic            w_redirect;
  logic [XLEN-1:0] w_target;
  logic            w_kill;

  logic            r_rf_we;
  logic [RDW-1:0]  r_rf_rd;
  logic [XLEN-1:0] r_rf_wdata;
  logic            r_retire_valid;
  logic [XLEN-1:0] r_retire_pc;
  logic            r_redirect_valid;
  logic [XLEN-1:0] r_redirect_pc;
  logic            r_trap_valid;

  // Picks the addressed lane out of the raw word and extends it per the load size.
  function automatic logic [XLEN-1:0] f_load_lane(input logic [2:0] f3, input logic [1:0] off,
                                                  input logic [XLEN-1:0] data);
    logic [7:0]  b;
    logic [15:0] h;
    b = data[{off, 3'b000} +: 8];
    h = off[1] ? data[31:16] : data[15:0];
    case (f3)
      F3_LB:   return {{(XLEN-8){b[7]}}, b};
      F3_LBU:  return {{(XLEN-8){1'b0}}, b};
      F3_LH:   return {{(XLEN-16){h[15]}}, h};
      F3_LHU:  return {{(XLEN-16){1'b0}}, h};
      default: return data;
    endcase
  endfunction

  assign w_in_entry = '{pc: in_pc, opcode: in_opcode, funct3: in_funct3, rd: in_rd,
                        alu_result: in_alu_result, rs1_data: in_rs1_data, imm: in_imm,
                        load_data: in_load_data};

  assign in_ready = (w_count < CW'(DEPTH));
  assign w_retire = (w_count != '0) && !wb_stall && !flush;
  // A redirecting or trapping retire empties the queue, so a same-cycle push would be a younger entry.
  assign w_push   = in_valid && in_ready && !flush && !(w_retire && w_kill);
  assign w_clear  = flush || (w_retire && w_kill);

  wb_fifo #(.T(wb_entry_t), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_dat   (w_in_entry),
    .i_pop   (w_retire),
    .i_clear (w_clear),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // Decode the head entry: write data, misalignment, and redirect target.
  always_comb begin
    w_off      = w_head.alu_result[1:0];
    w_misalign = 1'b0;
    w_we       = 1'b0;
    w_wdata    = '0;
    w_redirect = 1'b0;
    w_target   = '0;
    case (w_head.opcode)
      OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC: begin
        w_we    = 1'b1;
        w_wdata = w_head.alu_result;
      end
      OPC_LOAD: begin
        w_misalign = (((w_head.funct3 == F3_LH) || (w_head.funct3 == F3_LHU)) && w_off[0]) ||
                     ((w_head.funct3 == F3_LW) && (w_off != 2'b00));
        w_we       = !w_misalign;
        w_wdata    = f_load_lane(w_head.funct3, w_off, w_head.load_data);
      end
      OPC_JAL: begin
        w_we       = 1'b1;
        w_wdata    = w_head.pc + XLEN'(4);
        w_redirect = 1'b1;
        w_target   = w_head.pc + w_head.imm;
      end
      OPC_JALR: begin
        w_we       = 1'b1;
        w_wdata    = w_head.pc + XLEN'(4);
        w_redirect = 1'b1;
        w_target   = (w_head.rs1_data + w_head.imm) & ~XLEN'(1);
      end
      OPC_BRANCH: begin
        w_redirect = w_head.alu_result[0];
        w_target   = w_head.pc + w_head.imm;
      end
      default: ;
    endcase
    if (w_head.rd == '0) w_we = 1'b0;
    w_kill = w_redirect || w_misalign;
  end

  // Registered retire outputs; everything returns to zero on cycles without a retire.
  always_ff @(posedge clk) begin
    r_rf_we          <= 1'b0;
    r_rf_rd          <= '0;
    r_rf_wdata       <= '0;
    r_retire_valid   <= 1'b0;
    r_retire_pc      <= '0;
    r_redirect_valid <= 1'b0;
    r_redirect_pc    <= '0;
    r_trap_valid     <= 1'b0;
    if (rst_n && w_retire) begin
      r_retire_valid <= 1'b1;
      r_retire_pc    <= w_head.pc;
      r_trap_valid   <= w_misalign;
      if (w_we) begin
        r_rf_we    <= 1'b1;
        r_rf_rd    <= w_head.rd;
        r_rf_wdata <= w_wdata;
      end
      if (w_redirect) begin
        r_redirect_valid <= 1'b1;
        r_redirect_pc    <= w_target;
      end
    end
  end

  assign rf_we          = r_rf_we;
  assign rf_rd          = r_rf_rd;
  assign rf_wdata       = r_rf_wdata;
  assign retire_valid   = r_retire_valid;
  assign retire_pc      = r_retire_pc;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign trap_valid     = r_trap_valid;

endmodule

// File: tb/tb_write_back_queue.sv
// Directed bench for write_back_queue: ALU, loads, jumps, branches, traps, stall, flush and reset.
module tb_write_back_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [6:0]  in_opcode = '0;
  logic [2:0]  in_funct3 = '0;
  logic [4:0]  in_rd = '0;
  logic [31:0] in_alu_result = '0;
  logic [31:0] in_rs1_data = '0;
  logic [31:0] in_imm = '0;
  logic [31:0] in_load_data = '0;
  logic        wb_stall = 1'b0;
  logic        flush = 1'b0;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        retire_valid;
  logic [31:0] retire_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  write_back_queue #(.XLEN(32), .DEPTH(2), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_rd(in_rd), .in_alu_result(in_alu_result),
    .in_rs1_data(in_rs1_data), .in_imm(in_imm), .in_load_data(in_load_data),
    .wb_stall(wb_stall), .flush(flush), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .trap_valid(trap_valid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rs1,
                       input logic [31:0] imm, input logic [31:0] ld);
    in_valid = 1'b1; in_pc = pc; in_opcode = opc; in_funct3 = f3; in_rd = rd;
    in_alu_result = alu; in_rs1_data = rs1; in_imm = imm; in_load_data = ld;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; step(); step(); rst_n = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL reset_retire: got %b want 0", retire_valid); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
    checks++; if (redirect_valid !== 1'b0 || trap_valid !== 1'b0) begin errors++; $display("FAIL reset_redir_trap: got %b/%b want 0/0", redirect_valid, trap_valid); end
  endtask

  task automatic test_alu();
    offer(32'h0000_0040, 7'b0010011, 3'b000, 5'd5, 32'h0000_002A, 0, 0, 0); step();
    checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL addi_early: got %b want 0", retire_valid); end
    idle(); step();
    checks++; if (retire_valid !== 1'b1 || retire_pc !== 32'h40) begin errors++; $display("FAIL addi_retire: got %b pc %h want 1 pc 00000040", retire_valid, retire_pc); end
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wdata !== 32'h2A) begin errors++; $display("FAIL addi_write: got we %b rd %0d data %h want 1 5 0000002a", rf_we, rf_rd, rf_wdata); end
    step();
    checks++; if (retire_valid !== 1'b0 || rf_we !== 1'b0) begin errors++; $display("FAIL addi_pulse: got %b/%b want 0/0", retire_valid, rf_we); end
    // rd = x0 never writes
    offer(32'h44, 7'b0110011, 3'b000, 5'd0, 32'h1234, 0, 0, 0); step(); idle(); step();
    checks++; if (retire_valid !== 1'b1 || rf_we !== 1'b0) begin errors++; $display("FAIL x0_write: got retire %b we %b want 1 0", retire_valid, rf_we); end
  endtask

  task automatic test_loads();
    offer(32'h50, 7'b0000011, 3'b000, 5'd6, 32'h0000_1003, 0, 0, 32'h80FF_0000); step(); idle(); step();
    checks++; if (rf_we !== 1'b1 || rf_wdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_sext: got we %b data %h want 1 ffffff80", rf_we, rf_wdata); end
    offer(32'h54, 7'b0000011, 3'b100, 5'd6, 32'h0000_1003, 0, 0, 32'h80FF_0000); step(); idle(); step();
    checks++; if (rf_wdata !== 32'h0000_0080) begin errors++; $display("FAIL lbu_zext: got %h want 00000080", rf_wdata); end
    offer(32'h58, 7'b0000011, 3'b101, 5'd7, 32'h0000_1002, 0, 0, 32'h80FF_0000); step(); idle(); step();
    checks++; if (rf_wdata !== 32'h0000_80FF || trap_valid !== 1'b0) begin errors++; $display("FAIL lhu_hi: got %h trap %b want 000080ff 0", rf_wdata, trap_valid); end
    offer(32'h5C, 7'b0000011, 3'b001, 5'd7, 32'h0000_1002, 0, 0, 32'h80FF_0000); step(); idle(); step();
    checks++; if (rf_wdata !== 32'hFFFF_80FF) begin errors++; $display("FAIL lh_sext: got %h want ffff80ff", rf_wdata); end
  endtask

  task automatic test_jumps();
    wb_stall = 1'b1;
    offer(32'h100, 7'b1100111, 3'b000, 5'd1, 0, 32'h2001, 32'h4, 0); step();
    offer(32'h104, 7'b0010011, 3'b000, 5'd9, 32'h99, 0, 0, 0); step();
    idle(); wb_stall = 1'b0; step();
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd1 || rf_wdata !== 32'h104) begin errors++; $display("FAIL jalr_link: got we %b rd %0d data %h want 1 1 00000104", rf_we, rf_rd, rf_wdata); end
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h2004) begin errors++; $display("FAIL jalr_target: got %b %h want 1 00002004", redirect_valid, redirect_pc); end
    step();
    checks++; if (retire_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL jalr_younger_dropped: got retire %b ready %b want 0 1", retire_valid, in_ready); end
    offer(32'h400, 7'b1101111, 3'b000, 5'd1, 0, 0, 32'h20, 0); step(); idle(); step();
    checks++; if (rf_wdata !== 32'h404 || redirect_valid !== 1'b1 || redirect_pc !== 32'h420) begin errors++; $display("FAIL jal: got data %h redir %b %h want 00000404 1 00000420", rf_wdata, redirect_valid, redirect_pc); end
  endtask

  task automatic test_branch();
    offer(32'h200, 7'b1100011, 3'b000, 5'd0, 32'h1, 0, 32'hFFFF_FFF8, 0); step(); idle(); step();
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1F8 || rf_we !== 1'b0) begin errors++; $display("FAIL br_taken: got redir %b %h we %b want 1 000001f8 0", redirect_valid, redirect_pc, rf_we); end
    offer(32'h200, 7'b1100011, 3'b000, 5'd0, 32'h0, 0, 32'hFFFF_FFF8, 0); step(); idle(); step();
    checks++; if (retire_valid !== 1'b1 || redirect_valid !== 1'b0) begin errors++; $display("FAIL br_not_taken: got retire %b redir %b want 1 0", retire_valid, redirect_valid); end
  endtask

  task automatic test_trap();
    wb_stall = 1'b1;
    offer(32'h300, 7'b0000011, 3'b010, 5'd3, 32'h0000_1002, 0, 0, 32'hDEAD_BEEF); step();
    offer(32'h304, 7'b0010011, 3'b000, 5'd4, 32'h77, 0, 0, 0); step();
    idle(); wb_stall = 1'b0; step();
    checks++; if (trap_valid !== 1'b1 || rf_we !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL lw_trap: got trap %b we %b redir %b want 1 0 0", trap_valid, rf_we, redirect_valid); end
    step();
    checks++; if (retire_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL trap_emptied: got retire %b ready %b want 0 1", retire_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    wb_stall = 1'b1;
    offer(32'h500, 7'b0010011, 3'b000, 5'd8, 32'h11, 0, 0, 0); step();
    offer(32'h504, 7'b0010011, 3'b000, 5'd9, 32'h22, 0, 0, 0); step();
    offer(32'h508, 7'b0010011, 3'b000, 5'd10, 32'h33, 0, 0, 0);
    checks++; if (in_ready !== 1'b0 || retire_valid !== 1'b0) begin errors++; $display("FAIL stall_full: got ready %b retire %b want 0 0", in_ready, retire_valid); end
    step();
    checks++; if (in_ready !== 1'b0 || retire_valid !== 1'b0) begin errors++; $display("FAIL stall_hold: got ready %b retire %b want 0 0", in_ready, retire_valid); end
    // release with a push still offered: full queue refuses it while popping
    wb_stall = 1'b0; step();
    checks++; if (rf_rd !== 5'd8 || rf_wdata !== 32'h11 || in_ready !== 1'b1) begin errors++; $display("FAIL order_a: got rd %0d data %h ready %b want 8 00000011 1", rf_rd, rf_wdata, in_ready); end
    step(); idle();
    checks++; if (rf_rd !== 5'd9 || rf_wdata !== 32'h22) begin errors++; $display("FAIL order_b: got rd %0d data %h want 9 00000022", rf_rd, rf_wdata); end
    step();
    checks++; if (rf_rd !== 5'd10 || rf_wdata !== 32'h33 || retire_pc !== 32'h508) begin errors++; $display("FAIL order_c: got rd %0d data %h pc %h want 10 00000033 00000508", rf_rd, rf_wdata, retire_pc); end
    step();
    checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL drained: got %b want 0", retire_valid); end
  endtask

  task automatic test_flush();
    wb_stall = 1'b1;
    offer(32'h600, 7'b0010011, 3'b000, 5'd11, 32'h1, 0, 0, 0); step();
    offer(32'h604, 7'b0010011, 3'b000, 5'd12, 32'h2, 0, 0, 0); step();
    offer(32'h608, 7'b0010011, 3'b000, 5'd13, 32'h3, 0, 0, 0);
    wb_stall = 1'b0; flush = 1'b1; step();
    checks++; if (retire_valid !== 1'b0 || rf_we !== 1'b0) begin errors++; $display("FAIL flush_cycle: got retire %b we %b want 0 0", retire_valid, rf_we); end
    idle(); flush = 1'b0; step();
    checks++; if (retire_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_empty: got retire %b ready %b want 0 1", retire_valid, in_ready); end
  endtask

  task automatic test_reset_mid();
    offer(32'h700, 7'b1101111, 3'b000, 5'd1, 0, 0, 32'h40, 0); step(); idle();
    rst_n = 1'b0; step();
    checks++; if (retire_valid !== 1'b0 || redirect_valid !== 1'b0 || rf_we !== 1'b0) begin errors++; $display("FAIL rst_mid_out: got %b/%b/%b want 0/0/0", retire_valid, redirect_valid, rf_we); end
    rst_n = 1'b1; step();
    checks++; if (retire_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_empty: got retire %b ready %b want 0 1", retire_valid, in_ready); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_jumps();
    test_branch();
    test_trap();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
